// File: rtl/dpb_pkg.sv
// Shared types and constants for the dirty-pod broker source arbiter.
package dpb_pkg;

    localparam int unsigned DPB_NSRC  = 3;
    localparam int unsigned DPB_PTR_W = 16;

    typedef enum logic [1:0] {
        DPB_SRC_UTM = 2'd0,
        DPB_SRC_PRC = 2'd1,
        DPB_SRC_PFS = 2'd2
    } dpb_src_e;

    typedef logic [DPB_PTR_W-1:0] dpb_pod_ptr_t;

    typedef struct packed {
        dpb_src_e     src;
        dpb_pod_ptr_t ptr;
    } dpb_arb_entry_t;

    // Round-robin successor over the three sources.
    function automatic logic [1:0] dpb_next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/dpb_skid_fifo.sv
// Two-entry in-order buffer; head is presented directly from storage.
module dpb_skid_fifo
    import dpb_pkg::*;
#(
    parameter type entry_t = dpb_arb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpb_src_arb.sv
// Weighted round-robin arbiter merging UTM/PRC/PFS dirty-pod pointers into
// one buffered return path, with per-source saturating grant counters.
module dpb_src_arb
    import dpb_pkg::*;
#(
    parameter int unsigned PTR_W = 16,
    parameter int unsigned WGT_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3*WGT_W-1:0]        cfg_wgt,
    input  logic [2:0]                src_valid,
    input  logic [3*PTR_W-1:0]        src_ptr,
    output logic [2:0]                src_ready,
    output logic                      out_valid,
    output logic [PTR_W-1:0]          out_ptr,
    output logic [1:0]                out_src,
    input  logic                      out_ready,
    input  logic                      cnt_clr,
    output logic [3*CNT_W-1:0]        cnt_grant
);

    typedef struct packed {
        dpb_src_e         src;
        logic [PTR_W-1:0] ptr;
    } entry_t;

    logic [WGT_W-1:0]    wgt        [DPB_NSRC];
    logic [WGT_W-1:0]    credit     [DPB_NSRC];
    logic [WGT_W-1:0]    eff_credit [DPB_NSRC];
    logic [CNT_W-1:0]    cnt        [DPB_NSRC];
    logic [DPB_NSRC-1:0] req, has_cred, elig, grant;
    logic                reload, buf_full, buf_empty, xfer, gnt_last, found;
    logic [1:0]          rr_ptr, gnt_idx;
    logic [PTR_W-1:0]    gnt_ptr;
    int unsigned         idx;
    entry_t              push_entry, head;

    always_comb begin
        for (int unsigned i = 0; i < DPB_NSRC; i++) begin
            wgt[i]      = cfg_wgt[i*WGT_W +: WGT_W];
            req[i]      = src_valid[i] & (wgt[i] != '0);
            has_cred[i] = req[i] & (credit[i] != '0);
        end
    end

    // Reload is folded into this cycle's decision so exhausting credits never costs a bubble.
    assign reload = ~|has_cred & |req;

    always_comb begin
        for (int unsigned i = 0; i < DPB_NSRC; i++) begin
            eff_credit[i] = reload ? wgt[i] : credit[i];
            elig[i]       = req[i] & (eff_credit[i] != '0);
        end
    end

    always_comb begin
        grant   = '0;
        gnt_idx = rr_ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < DPB_NSRC; off++) begin
            idx = (32'(rr_ptr) + off) % DPB_NSRC;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = 2'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_ptr  = '0;
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < DPB_NSRC; i++) begin
            if (grant[i]) begin
                gnt_ptr  = src_ptr[i*PTR_W +: PTR_W];
                gnt_last = (eff_credit[i] == WGT_W'(1));
            end
        end
    end

    assign src_ready      = grant & {DPB_NSRC{~buf_full & ~rst}};
    assign xfer           = |src_ready;
    assign push_entry.src = dpb_src_e'(gnt_idx);
    assign push_entry.ptr = gnt_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DPB_NSRC; i++) credit[i] <= '0;
            rr_ptr <= 2'd0;
        end else if (xfer) begin
            for (int unsigned i = 0; i < DPB_NSRC; i++) begin
                if (grant[i])    credit[i] <= eff_credit[i] - WGT_W'(1);
                else if (reload) credit[i] <= wgt[i];
            end
            // Hold the pointer on a source while it still has burst credit.
            rr_ptr <= gnt_last ? dpb_next_src(gnt_idx) : gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int unsigned i = 0; i < DPB_NSRC; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DPB_NSRC; i++) begin
                if (src_ready[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_grant = '0;
        for (int unsigned i = 0; i < DPB_NSRC; i++) cnt_grant[i*CNT_W +: CNT_W] = cnt[i];
    end

    dpb_skid_fifo #(
        .entry_t (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (push_entry),
        .pop       (out_ready),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign out_valid = ~buf_empty;
    assign out_ptr   = head.ptr;
    assign out_src   = head.src;

endmodule
